oc8051_iram_bist_ctrl: RTL and testbench

March-test BIST controller and port arbiter for the 8051 internal RAM. It sits between the core's IRAM read/write ports and the two-port internal RAM. When idle it passes core accesses straight through. On `start` it takes the RAM ports, stalls the core, runs a 4-element march test over every word, then reports pass/fail with the first failing address and data. The RAM read port has one cycle of registered latency and bypasses write data when the read and write addresses match.

---
 rtl/oc8051_iram_bist_ctrl_pkg.sv | 34 +++
 rtl/oc8051_iram_bist_ctrl_if.sv | 46 ++++
 rtl/oc8051_iram_bist_ctrl_addr_gen.sv | 44 ++++
 rtl/oc8051_iram_bist_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_oc8051_iram_bist_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/oc8051_iram_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_bist_pkg
//  Purpose  : Shared types and constants for the IRAM march-test BIST
//             controller: FSM state encoding, march element codes, data
//             width and the default background pattern.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package oc8051_bist_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1R   = 4'd2,
        ST_M1W   = 4'd3,
        ST_M2R   = 4'd4,
        ST_M2W   = 4'd5,
        ST_M3    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } bist_state_t;

    localparam logic [1:0] E_M0 = 2'd0;
    localparam logic [1:0] E_M1 = 2'd1;
    localparam logic [1:0] E_M2 = 2'd2;
    localparam logic [1:0] E_M3 = 2'd3;

    localparam logic [DATA_W-1:0] BG_DEFAULT = 8'h55;

endpackage
`default_nettype wire

// File: rtl/oc8051_iram_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_iram_bist_ctrl_if
//  Purpose  : Bundles the core-side IRAM request port and the RAM-side drive
//             port seen by the BIST controller.
//  Ports    : core_rd_addr/core_rd_en/core_wr_addr/core_wr_data/core_wr
//             (core requests), core_stall (stall back to core),
//             ram_rd_addr/ram_rd_en/ram_wr_addr/ram_wr_data/ram_wr/ram_wr_en
//             (RAM drives), ram_rd_data (RAM read return, 1-cycle latency).
//             master = controller side, slave = core + RAM side.
//  Revision : 1.0  initial release
// ============================================================================
interface oc8051_iram_bist_ctrl_if;
    import oc8051_bist_pkg::*;

    logic [DATA_W-1:0] core_rd_addr;
    logic              core_rd_en;
    logic [DATA_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_wr;
    logic              core_stall;

    logic [DATA_W-1:0] ram_rd_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_wr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        input  core_rd_addr, core_rd_en, core_wr_addr, core_wr_data, core_wr,
        input  ram_rd_data,
        output core_stall,
        output ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
    );

    modport slave (
        output core_rd_addr, core_rd_en, core_wr_addr, core_wr_data, core_wr,
        output ram_rd_data,
        input  core_stall,
        input  ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
    );

endinterface
`default_nettype wire

// File: rtl/oc8051_iram_bist_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_bist_addr_gen
//  Purpose  : AW-bit up/down march address counter. Loads 0 or the top
//             address, steps in the selected direction, and flags the last
//             address of the current direction (N-1 going up, 0 going down).
//  Ports    : clk, rst, load_zero, load_max, step, dir_up (controls),
//             addr (current address), at_end (last address reached).
//  Revision : 1.0  initial release
// ============================================================================
module oc8051_bist_addr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_zero,
    input  logic          load_max,
    input  logic          step,
    input  logic          dir_up,
    output logic [AW-1:0] addr,
    output logic          at_end
);

    localparam logic [AW-1:0] ADDR_MAX = '1;

    logic [AW-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (load_zero) begin
            r_addr <= '0;
        end else if (load_max) begin
            r_addr <= ADDR_MAX;
        end else if (step) begin
            r_addr <= dir_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
        end
    end

    assign addr   = r_addr;
    assign at_end = dir_up ? (r_addr == ADDR_MAX) : (r_addr == '0);

endmodule
`default_nettype wire

// File: rtl/oc8051_iram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_iram_bist_ctrl
//  Purpose  : March-test BIST controller and port arbiter for the 8051
//             internal RAM. Passes core accesses through when idle; on start
//             takes the RAM, stalls the core and runs a 4-element march
//             (w0 ; up r0 w1 ; down r1 w0 ; up r0) over 2^AW words, then
//             reports pass/fail with the first failing address/data/element.
//  Ports    : clk, rst (sync, active-high), start (run pulse),
//             bus (core/RAM interface, master side),
//             busy, done, fail, fail_addr, fail_data, fail_elem (status).
//  Revision : 1.0  initial release
// ============================================================================
module oc8051_iram_bist_ctrl
    import oc8051_bist_pkg::*;
#(
    parameter int                AW = 4,
    parameter logic [DATA_W-1:0] BG = BG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    oc8051_iram_bist_ctrl_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [AW-1:0]          fail_addr,
    output logic [DATA_W-1:0]      fail_data,
    output logic [1:0]             fail_elem
);

    bist_state_t       r_state;
    bist_state_t       w_next;

    logic [AW-1:0]     w_addr;
    logic              w_at_end;
    logic              w_ld_zero;
    logic              w_ld_max;
    logic              w_step;
    logic              w_dir_up;

    logic              w_busy;
    logic              w_start_ok;
    logic              w_bist_rd;
    logic              w_bist_wr;
    logic [DATA_W-1:0] w_bist_wdata;
    logic [DATA_W-1:0] w_chk_exp;
    logic [1:0]        w_chk_elem;

    // Compare stage: a BIST read issued this cycle is checked next cycle,
    // when the RAM's registered read data is valid.
    logic              r_chk_vld;
    logic [AW-1:0]     r_chk_addr;
    logic [DATA_W-1:0] r_chk_exp;
    logic [1:0]        r_chk_elem;

    logic              r_fail;
    logic [AW-1:0]     r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [1:0]        r_fail_elem;

    assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_start_ok = start && !w_busy;

    oc8051_bist_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_zero (w_ld_zero),
        .load_max  (w_ld_max),
        .step      (w_step),
        .dir_up    (w_dir_up),
        .addr      (w_addr),
        .at_end    (w_at_end)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)    w_next = ST_M0;
            ST_M0:            if (w_at_end) w_next = ST_M1R;
            ST_M1R:                         w_next = ST_M1W;
            ST_M1W:           w_next = w_at_end ? ST_M2R : ST_M1R;
            ST_M2R:                         w_next = ST_M2W;
            ST_M2W:           w_next = w_at_end ? ST_M3 : ST_M2R;
            ST_M3:            if (w_at_end) w_next = ST_DRAIN;
            ST_DRAIN:                       w_next = ST_DONE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_ld_zero    = 1'b0;
        w_ld_max     = 1'b0;
        w_step       = 1'b0;
        w_dir_up     = 1'b1;
        w_bist_rd    = 1'b0;
        w_bist_wr    = 1'b0;
        w_bist_wdata = BG;
        w_chk_exp    = BG;
        w_chk_elem   = E_M0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_ld_zero = start;
            end
            ST_M0: begin
                w_bist_wr = 1'b1;
                w_ld_zero = w_at_end;
                w_step    = !w_at_end;
            end
            ST_M1R: begin
                w_bist_rd  = 1'b1;
                w_chk_exp  = BG;
                w_chk_elem = E_M1;
            end
            ST_M1W: begin
                w_bist_wr    = 1'b1;
                w_bist_wdata = ~BG;
                // Element 2 runs downward, so it starts from the top word.
                w_ld_max     = w_at_end;
                w_step       = !w_at_end;
            end
            ST_M2R: begin
                w_dir_up   = 1'b0;
                w_bist_rd  = 1'b1;
                w_chk_exp  = ~BG;
                w_chk_elem = E_M2;
            end
            ST_M2W: begin
                w_dir_up  = 1'b0;
                w_bist_wr = 1'b1;
                w_ld_zero = w_at_end;
                w_step    = !w_at_end;
            end
            ST_M3: begin
                w_bist_rd  = 1'b1;
                w_chk_exp  = BG;
                w_chk_elem = E_M3;
                w_step     = !w_at_end;
            end
            default: begin
            end
        endcase
    end

    // Port arbitration: core owns the RAM unless a run is in progress.
    always_comb begin
        bus.core_stall = w_busy;
        if (w_busy) begin
            bus.ram_rd_addr = DATA_W'(w_addr);
            bus.ram_rd_en   = w_bist_rd;
            bus.ram_wr_addr = DATA_W'(w_addr);
            bus.ram_wr_data = w_bist_wdata;
            bus.ram_wr      = w_bist_wr;
            bus.ram_wr_en   = w_bist_wr;
        end else begin
            bus.ram_rd_addr = bus.core_rd_addr;
            bus.ram_rd_en   = bus.core_rd_en;
            bus.ram_wr_addr = bus.core_wr_addr;
            bus.ram_wr_data = bus.core_wr_data;
            bus.ram_wr      = bus.core_wr;
            bus.ram_wr_en   = bus.core_wr;
        end
    end

    assign busy = w_busy;
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------ compare/capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_vld  <= 1'b0;
            r_chk_addr <= '0;
            r_chk_exp  <= '0;
            r_chk_elem <= '0;
        end else begin
            r_chk_vld  <= w_busy && w_bist_rd;
            r_chk_addr <= w_addr;
            r_chk_exp  <= w_chk_exp;
            r_chk_elem <= w_chk_elem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_elem <= '0;
        end else if (r_chk_vld && (bus.ram_rd_data != r_chk_exp)) begin
            r_fail <= 1'b1;
            // Only the first miscompare of a run is recorded.
            if (!r_fail) begin
                r_fail_addr <= r_chk_addr;
                r_fail_data <= bus.ram_rd_data;
                r_fail_elem <= r_chk_elem;
            end
        end
    end

    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign fail_elem = r_fail_elem;

endmodule
`default_nettype wire

// File: tb/tb_oc8051_iram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oc8051_iram_bist_ctrl
//  Purpose  : Self-checking bench for oc8051_iram_bist_ctrl with a RAM model
//             (registered read, write bypass, optional stuck-at-1 on word 5
//             bit 0) and a march-sequence reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oc8051_iram_bist_ctrl;
    import oc8051_bist_pkg::*;

    localparam int          AW  = 4;
    localparam int          N   = 1 << AW;
    localparam int          RUN = 6 * N + 1;
    localparam logic [7:0]  BGV = 8'h55;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [7:0]    fail_data;
    logic [1:0]    fail_elem;

    oc8051_iram_bist_ctrl_if bus ();

    oc8051_iram_bist_ctrl #(.AW(AW), .BG(BGV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // ---------------------------------------------------------- RAM model
    logic [7:0] mem [0:255];
    logic       stuck5 = 1'b0;

    function automatic logic [7:0] stored(input logic [7:0] a, input logic [7:0] d);
        return (stuck5 && a == 8'd5) ? (d | 8'h01) : d;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_rd_en)
            bus.ram_rd_data <= (bus.ram_wr && bus.ram_wr_en && bus.ram_wr_addr == bus.ram_rd_addr)
                               ? stored(bus.ram_wr_addr, bus.ram_wr_data) : mem[bus.ram_rd_addr];
        if (bus.ram_wr && bus.ram_wr_en)
            mem[bus.ram_wr_addr] <= stored(bus.ram_wr_addr, bus.ram_wr_data);
    end

    // ------------------------------------------------- march reference model
    typedef struct packed {
        logic          rd;
        logic [AW-1:0] ra;
        logic          wr;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        logic [7:0]    exp;
        logic [1:0]    el;
    } op_t;

    op_t           ops [RUN];
    logic          m_fail;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    logic [1:0]    m_elem;

    task automatic build_ops();
        int k = 0;
        for (int a = 0; a < N; a++) begin
            ops[k] = '0; ops[k].wr = 1'b1; ops[k].wa = AW'(a); ops[k].wd = BGV; k++;
        end
        for (int a = 0; a < N; a++) begin
            ops[k] = '0; ops[k].rd = 1'b1; ops[k].ra = AW'(a); ops[k].exp = BGV; ops[k].el = 2'd1; k++;
            ops[k] = '0; ops[k].wr = 1'b1; ops[k].wa = AW'(a); ops[k].wd = ~BGV; k++;
        end
        for (int a = N - 1; a >= 0; a--) begin
            ops[k] = '0; ops[k].rd = 1'b1; ops[k].ra = AW'(a); ops[k].exp = ~BGV; ops[k].el = 2'd2; k++;
            ops[k] = '0; ops[k].wr = 1'b1; ops[k].wa = AW'(a); ops[k].wd = BGV; k++;
        end
        for (int a = 0; a < N; a++) begin
            ops[k] = '0; ops[k].rd = 1'b1; ops[k].ra = AW'(a); ops[k].exp = BGV; ops[k].el = 2'd3; k++;
        end
        ops[k] = '0;   // final cycle only finishes the last compare
    endtask

    task automatic predict(input bit stuck);
        logic [7:0] m [N];
        logic [7:0] v;
        m_fail = 1'b0; m_addr = '0; m_data = '0; m_elem = '0;
        for (int i = 0; i < N; i++) m[i] = 8'h00;
        for (int k = 0; k < RUN; k++) begin
            if (ops[k].rd) begin
                v = m[ops[k].ra];
                if (v != ops[k].exp) begin
                    if (!m_fail) begin
                        m_addr = ops[k].ra; m_data = v; m_elem = ops[k].el;
                    end
                    m_fail = 1'b1;
                end
            end
            if (ops[k].wr)
                m[ops[k].wa] = (stuck && ops[k].wa == AW'(5)) ? (ops[k].wd | 8'h01) : ops[k].wd;
        end
    endtask

    // ----------------------------------------------------- compare process
    int mode = 0;   // 0 = no check, 1 = BIST run, 2 = core passthrough
    int idx  = 0;

    always @(negedge clk) begin
        if (mode == 1) begin
            if (idx < RUN) begin
                check($sformatf("run_cyc%0d", idx + 1),
                    64'({busy, bus.core_stall, done, bus.ram_rd_en,
                         bus.ram_rd_en ? bus.ram_rd_addr : 8'h00,
                         bus.ram_wr, bus.ram_wr_en,
                         bus.ram_wr ? bus.ram_wr_addr : 8'h00,
                         bus.ram_wr ? bus.ram_wr_data : 8'h00}),
                    64'({1'b1, 1'b1, 1'b0, ops[idx].rd,
                         ops[idx].rd ? 8'(ops[idx].ra) : 8'h00,
                         ops[idx].wr, ops[idx].wr,
                         ops[idx].wr ? 8'(ops[idx].wa) : 8'h00,
                         ops[idx].wr ? ops[idx].wd : 8'h00}));
                idx++;
            end else begin
                check("run_end",
                    64'({busy, bus.core_stall, done, fail, fail_addr, fail_data, fail_elem}),
                    64'({1'b0, 1'b0, 1'b1, m_fail, m_addr, m_data, m_elem}));
                mode = 2;
            end
        end else if (mode == 2) begin
            check("passthru",
                64'({busy, bus.core_stall, bus.ram_rd_addr, bus.ram_rd_en, bus.ram_wr_addr,
                     bus.ram_wr_data, bus.ram_wr, bus.ram_wr_en}),
                64'({1'b0, 1'b0, bus.core_rd_addr, bus.core_rd_en, bus.core_wr_addr,
                     bus.core_wr_data, bus.core_wr, bus.core_wr}));
        end
    end

    // -------------------------------------------------------- stimulus
    task automatic core_rand();
        bus.core_rd_addr = 8'($urandom);
        bus.core_rd_en   = 1'($urandom);
        bus.core_wr_addr = 8'($urandom_range(16, 255));
        bus.core_wr_data = 8'($urandom);
        bus.core_wr      = 1'($urandom);
    endtask

    task automatic run_bist(input bit stuck, input int start_again_at, input int rst_at,
                            output int busy_cnt);
        int cyc;
        stuck5 = stuck;
        predict(stuck);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idx = 0; mode = 1; cyc = 1; busy_cnt = 0;
        while (mode == 1 && cyc <= RUN + 20) begin
            if (busy) busy_cnt++;
            start = (cyc == start_again_at);
            if (cyc == rst_at) begin
                rst  = 1'b1;
                mode = 0;
            end
            core_rand();
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (mode == 1) begin
            check("run_timeout", 64'(mode), 64'(2));
            mode = 2;
        end
    endtask

    int bc;

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.core_rd_addr = '0; bus.core_rd_en = 1'b0;
        bus.core_wr_addr = '0; bus.core_wr_data = '0; bus.core_wr = 1'b0;
        bus.ram_rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        build_ops();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset", 64'({busy, done, fail, bus.core_stall, fail_addr, fail_data, fail_elem}), 64'(0));
        mode = 2;

        // Idle passthrough: write 3C to 9, read it back.
        @(posedge clk); #1
        bus.core_wr = 1'b1; bus.core_wr_addr = 8'd9; bus.core_wr_data = 8'h3C; bus.core_rd_en = 1'b0;
        @(posedge clk); #1
        bus.core_wr = 1'b0; bus.core_rd_en = 1'b1; bus.core_rd_addr = 8'd9;
        @(posedge clk); #1 bus.core_rd_en = 1'b0;
        @(negedge clk);
        check("idle_rd_data", 64'({bus.core_stall, bus.ram_rd_data}), 64'({1'b0, 8'h3C}));
        repeat (6) begin @(posedge clk); #1 core_rand(); end
        @(posedge clk); #1 bus.core_wr = 1'b0; bus.core_rd_en = 1'b0;

        // Fault-free run.
        run_bist(1'b0, 0, 0, bc);
        check("p_busy_cycles", 64'(bc), 64'(97));
        check("p_status", 64'({done, fail}), 64'({1'b1, 1'b0}));
        for (int i = 0; i < N; i++)
            check($sformatf("p_word%0d", i), 64'(mem[i]), 64'(8'h55));

        // Word 5 bit 0 stuck-at-1, started from DONE.
        run_bist(1'b1, 0, 0, bc);
        check("s_capture", 64'({done, fail, fail_addr, fail_data, fail_elem}),
              64'({1'b1, 1'b1, 4'd5, 8'hAB, 2'd2}));

        // Second start at cycle 40 ignored; core strobes during run discarded.
        run_bist(1'b0, 40, 0, bc);
        check("i_busy_cycles", 64'(bc), 64'(97));
        check("i_status", 64'({done, fail}), 64'({1'b1, 1'b0}));

        // Reset at cycle 50.
        run_bist(1'b0, 0, 50, bc);
        rst = 1'b0;
        @(negedge clk);
        check("r_flags", 64'({busy, done, fail, bus.core_stall}), 64'(0));
        check("r_ports", 64'({bus.ram_rd_addr, bus.ram_rd_en, bus.ram_wr_addr, bus.ram_wr_data, bus.ram_wr}),
              64'({bus.core_rd_addr, bus.core_rd_en, bus.core_wr_addr, bus.core_wr_data, bus.core_wr}));
        mode = 2;
        repeat (4) begin @(posedge clk); #1 core_rand(); end
        @(negedge clk);
        mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
